// File: rtl/fpu_wb_cmd_queue_pkg.sv
// Shared definitions for the FPU wishbone command queue: register map,
// STATUS/CTRL bit positions, result entry layout and the byte-merge helper.
package fpu_wb_cmd_queue_pkg;

   localparam logic [7:0] OFF_A      = 8'h00;
   localparam logic [7:0] OFF_B      = 8'h04;
   localparam logic [7:0] OFF_C      = 8'h08;
   localparam logic [7:0] OFF_RES    = 8'h0C;
   localparam logic [7:0] OFF_FLAGS  = 8'h10;
   localparam logic [7:0] OFF_STATUS = 8'h14;
   localparam logic [7:0] OFF_CTRL   = 8'h18;
   localparam logic [7:0] OFF_OP     = 8'h1C;
   localparam logic [7:0] OFF_RM     = 8'h24;

   localparam int ST_CMD_FULL  = 16;
   localparam int ST_RES_EMPTY = 17;
   localparam int ST_CMD_OVF   = 24;
   localparam int ST_RES_UNF   = 25;
   localparam int ST_SPURIOUS  = 26;

   localparam int CTRL_IRQ_EN = 0;
   localparam int CTRL_FLUSH  = 1;

   // flags are packed MSB-first as NV,DZ,OF,UF,NX
   typedef struct packed {
      logic [4:0]  flags;
      logic [31:0] result;
   } res_entry_t;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            merged[i*8 +: 8] = new_val[i*8 +: 8];
         end else begin
            merged[i*8 +: 8] = old_val[i*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/fpu_wb_cmd_queue_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count == CW'(0));
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= AW'(0);
         rd_ptr <= AW'(0);
         count  <= CW'(0);
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // storage is not reset; pointers alone define validity
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/fpu_wb_cmd_queue.sv
// Wishbone slave front-end for the FPU: stages operands, queues committed
// commands toward the core and buffers returned results for software.
module fpu_wb_cmd_queue
   import fpu_wb_cmd_queue_pkg::*;
#(
   parameter logic [31:0] BASE_ADR  = 32'h3000_0000,
   parameter int          OP_W      = 12,
   parameter int          CMD_DEPTH = 4,
   parameter int          RES_DEPTH = 4
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_adr_i,
   input  logic [31:0]     wbs_dat_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   output logic [31:0]     fpu_a_o,
   output logic [31:0]     fpu_b_o,
   output logic [31:0]     fpu_c_o,
   output logic [2:0]      fpu_rm_o,
   output logic [OP_W-1:0] fpu_op_o,
   output logic            fpu_valid_o,
   input  logic            fpu_ready_i,
   input  logic            fpu_res_valid_i,
   input  logic [31:0]     fpu_result_i,
   input  logic [4:0]      fpu_flags_i,
   output logic            irq_o
);

   localparam int CMD_W = 96 + 3 + OP_W;
   localparam int CCW   = $clog2(CMD_DEPTH) + 1;
   localparam int RCW   = $clog2(RES_DEPTH) + 1;

   logic [31:0]     a_reg;
   logic [31:0]     b_reg;
   logic [31:0]     c_reg;
   logic [OP_W-1:0] op_reg;
   logic [2:0]      rm_reg;
   logic            irq_en;
   logic            cmd_ovf;
   logic            res_unf;
   logic            spurious;
   logic [RCW-1:0]  outstanding;

   logic [7:0]      off;
   logic            req;
   logic            wr;
   logic            rd;
   logic [31:0]     cur;
   logic [31:0]     wr_val;
   logic [31:0]     rd_val;
   logic [31:0]     status;

   logic            commit;
   logic            flush;
   logic            status_w1c;
   logic [2:0]      w1c_bits;
   logic            issue;
   logic            ret;
   logic            spur_hit;
   logic            res_rd;
   logic            res_pop;

   logic [CMD_W-1:0] cmd_din;
   logic [CMD_W-1:0] cmd_dout;
   logic             cmd_full;
   logic             cmd_empty;
   logic [CCW-1:0]   cmd_count;
   res_entry_t       res_din;
   res_entry_t       res_dout;
   logic             res_full;
   logic             res_empty;
   logic [RCW-1:0]   res_count;

   assign off = wbs_adr_i[7:0];
   // ack is held off for one cycle after each transfer so a held strobe never double-acks
   assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~wbs_ack_o;
   assign wr  = req & wbs_we_i;
   assign rd  = req & ~wbs_we_i;

   always_comb begin
      status                     = 32'd0;
      status[7:0]                = 8'(cmd_count);
      status[15:8]               = 8'(res_count);
      status[ST_CMD_FULL]        = cmd_full;
      status[ST_RES_EMPTY]       = res_empty;
      status[ST_CMD_OVF]         = cmd_ovf;
      status[ST_RES_UNF]         = res_unf;
      status[ST_SPURIOUS]        = spurious;
   end

   always_comb begin
      cur    = 32'd0;
      rd_val = 32'd0;
      case (off)
         OFF_A:      begin cur = a_reg;                rd_val = cur; end
         OFF_B:      begin cur = b_reg;                rd_val = cur; end
         OFF_C:      begin cur = c_reg;                rd_val = cur; end
         OFF_OP:     begin cur = 32'(op_reg);          rd_val = cur; end
         OFF_RM:     begin cur = 32'(rm_reg);          rd_val = cur; end
         OFF_CTRL:   begin cur = 32'(irq_en);          rd_val = cur; end
         OFF_STATUS: begin cur = 32'd0;                rd_val = status; end
         OFF_RES:    begin cur = 32'd0;                rd_val = res_empty ? 32'd0 : res_dout.result; end
         OFF_FLAGS:  begin cur = 32'd0;                rd_val = res_empty ? 32'd0 : 32'(res_dout.flags); end
         default:    begin cur = 32'd0;                rd_val = 32'd0; end
      endcase
   end

   assign wr_val     = byte_merge(cur, wbs_dat_i, wbs_sel_i);
   assign commit     = wr & (off == OFF_OP) & wr_val[OP_W];
   assign flush      = wr & (off == OFF_CTRL) & wr_val[CTRL_FLUSH];
   assign status_w1c = wr & (off == OFF_STATUS);
   assign w1c_bits   = status_w1c ? (wbs_dat_i[ST_SPURIOUS:ST_CMD_OVF] & {3{wbs_sel_i[3]}}) : 3'b000;
   assign res_rd     = rd & (off == OFF_RES);
   assign res_pop    = res_rd & ~res_empty;

   // a new result is admitted only while res_count + in-flight leaves room for it
   assign fpu_valid_o = ~cmd_empty &
                        (({1'b0, res_count} + {1'b0, outstanding}) < (RCW+1)'(RES_DEPTH));
   assign issue    = fpu_valid_o & fpu_ready_i;
   assign ret      = fpu_res_valid_i & (outstanding != RCW'(0));
   assign spur_hit = fpu_res_valid_i & (outstanding == RCW'(0));

   assign cmd_din        = {a_reg, b_reg, c_reg, rm_reg, wr_val[OP_W-1:0]};
   assign res_din.flags  = fpu_flags_i;
   assign res_din.result = fpu_result_i;

   assign fpu_a_o  = fpu_valid_o ? cmd_dout[CMD_W-1 -: 32]      : 32'd0;
   assign fpu_b_o  = fpu_valid_o ? cmd_dout[CMD_W-33 -: 32]     : 32'd0;
   assign fpu_c_o  = fpu_valid_o ? cmd_dout[CMD_W-65 -: 32]     : 32'd0;
   assign fpu_rm_o = fpu_valid_o ? cmd_dout[OP_W+2:OP_W]        : 3'd0;
   assign fpu_op_o = fpu_valid_o ? cmd_dout[OP_W-1:0]           : {OP_W{1'b0}};

   sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .clr   (flush),
      .push  (commit),
      .pop   (issue),
      .din   (cmd_din),
      .dout  (cmd_dout),
      .full  (cmd_full),
      .empty (cmd_empty),
      .count (cmd_count)
   );

   sync_fifo #(.WIDTH(37), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .clr   (flush),
      .push  (ret),
      .pop   (res_pop),
      .din   (res_din),
      .dout  (res_dout),
      .full  (res_full),
      .empty (res_empty),
      .count (res_count)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= 32'd0;
         irq_o     <= 1'b0;
      end else begin
         wbs_ack_o <= req;
         wbs_dat_o <= rd ? rd_val : 32'd0;
         irq_o     <= irq_en & ~res_empty;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         a_reg  <= 32'd0;
         b_reg  <= 32'd0;
         c_reg  <= 32'd0;
         op_reg <= {OP_W{1'b0}};
         rm_reg <= 3'd0;
         irq_en <= 1'b0;
      end else if (wr) begin
         case (off)
            OFF_A:    a_reg  <= wr_val;
            OFF_B:    b_reg  <= wr_val;
            OFF_C:    c_reg  <= wr_val;
            OFF_OP:   op_reg <= wr_val[OP_W-1:0];
            OFF_RM:   rm_reg <= wr_val[2:0];
            OFF_CTRL: irq_en <= wr_val[CTRL_IRQ_EN];
            default:  a_reg  <= a_reg;
         endcase
      end else begin
         a_reg <= a_reg;
      end
   end

   // sticky error bits: write-1-clear first, a new event in the same cycle wins
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cmd_ovf  <= 1'b0;
         res_unf  <= 1'b0;
         spurious <= 1'b0;
      end else begin
         cmd_ovf  <= (cmd_ovf  & ~w1c_bits[0]) | (commit & cmd_full & ~issue);
         res_unf  <= (res_unf  & ~w1c_bits[1]) | (res_rd & res_empty);
         spurious <= (spurious & ~w1c_bits[2]) | spur_hit;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || flush) begin
         outstanding <= RCW'(0);
      end else begin
         case ({issue, ret})
            2'b10:   outstanding <= outstanding + RCW'(1);
            2'b01:   outstanding <= outstanding - RCW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_wb_cmd_queue.sv
// Directed bench for fpu_wb_cmd_queue with a simple core model and a
// scoreboard of expected results filled at commit time.
module tb_fpu_wb_cmd_queue;
   import fpu_wb_cmd_queue_pkg::*;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [31:0] fpu_a_o, fpu_b_o, fpu_c_o;
   logic [2:0]  fpu_rm_o;
   logic [11:0] fpu_op_o;
   logic        fpu_valid_o, fpu_ready_i, fpu_res_valid_i;
   logic [31:0] fpu_result_i;
   logic [4:0]  fpu_flags_i;
   logic        irq_o;

   int passed = 0;
   int total  = 0;
   int failed = 0;
   int issue_count = 0;

   logic [36:0] exp_q[$];
   logic [36:0] inflight[$];
   logic [31:0] st_a, st_b, st_c;
   logic [2:0]  st_rm;

   always #5 clk = ~clk;

   fpu_wb_cmd_queue dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .fpu_a_o(fpu_a_o), .fpu_b_o(fpu_b_o), .fpu_c_o(fpu_c_o),
      .fpu_rm_o(fpu_rm_o), .fpu_op_o(fpu_op_o), .fpu_valid_o(fpu_valid_o),
      .fpu_ready_i(fpu_ready_i), .fpu_res_valid_i(fpu_res_valid_i),
      .fpu_result_i(fpu_result_i), .fpu_flags_i(fpu_flags_i), .irq_o(irq_o)
   );

   function automatic logic [36:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [2:0] rm,
                                           input logic [11:0] op);
      logic [31:0] r;
      logic [4:0]  f;
      r = a ^ {b[15:0], b[31:16]} ^ c ^ {20'd0, op};
      f = op[4:0] ^ {2'b00, rm};
      return {f, r};
   endfunction

   // core model: records every accepted command and what it will return
   always @(posedge clk) begin
      if (!rst && fpu_valid_o && fpu_ready_i) begin
         inflight.push_back(core_fn(fpu_a_o, fpu_b_o, fpu_c_o, fpu_rm_o, fpu_op_o));
         issue_count++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_access(input logic we, input logic [7:0] off, input logic [31:0] dat,
                            input logic [3:0] sel, output logic [31:0] rdata);
      logic got;
      got = 1'b0;
      rdata = 32'd0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_adr_i = BASE | {24'd0, off}; wbs_dat_i = dat; wbs_sel_i = sel;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (wbs_ack_o) begin
            got = 1'b1;
            rdata = wbs_dat_o;
         end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      if (!got) check("wb_ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] dat);
      logic [31:0] dummy;
      wb_access(1'b1, off, dat, 4'hF, dummy);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] d);
      wb_access(1'b0, off, 32'd0, 4'hF, d);
   endtask

   task automatic stage(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [2:0] rm);
      wr(OFF_A, a); wr(OFF_B, b); wr(OFF_C, c); wr(OFF_RM, {29'd0, rm});
      st_a = a; st_b = b; st_c = c; st_rm = rm;
   endtask

   task automatic commit(input logic [11:0] op, input logic accepted);
      wr(OFF_OP, {19'd0, 1'b1, op});
      if (accepted) exp_q.push_back(core_fn(st_a, st_b, st_c, st_rm, op));
   endtask

   task automatic core_return();
      logic [36:0] r;
      int waited;
      waited = 0;
      while (inflight.size() == 0 && waited < 20) begin
         tick();
         waited++;
      end
      if (inflight.size() == 0) begin
         check("core_no_issue", 32'd0, 32'd1);
      end else begin
         r = inflight.pop_front();
         fpu_res_valid_i = 1'b1; fpu_result_i = r[31:0]; fpu_flags_i = r[36:32];
         tick();
         fpu_res_valid_i = 1'b0; fpu_result_i = 32'd0; fpu_flags_i = 5'd0;
      end
   endtask

   task automatic read_res(input string tag);
      logic [31:0] d;
      logic [36:0] e;
      rd(OFF_RES, d);
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check(tag, d, e[31:0]);
      end
   endtask

   initial begin
      logic [31:0] d, d2;
      int base_issue;
      rst = 1'b1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
      wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;
      fpu_ready_i = 1'b0; fpu_res_valid_i = 1'b0; fpu_result_i = 32'd0; fpu_flags_i = 5'd0;
      st_a = 32'd0; st_b = 32'd0; st_c = 32'd0; st_rm = 3'd0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("rst_dat", wbs_dat_o, 32'd0);
      check("rst_valid", {31'd0, fpu_valid_o}, 32'd0);
      check("rst_a", fpu_a_o, 32'd0);
      check("rst_irq", {31'd0, irq_o}, 32'd0);
      rd(OFF_STATUS, d);
      check("rst_status", d, 32'h0002_0000);

      // basic command, byte-select merge on A
      stage(32'h3F80_0000, 32'h4000_0000, 32'd0, 3'd0);
      commit(12'h001, 1'b1);
      check("cmd_valid", {31'd0, fpu_valid_o}, 32'd1);
      check("cmd_a", fpu_a_o, 32'h3F80_0000);
      check("cmd_b", fpu_b_o, 32'h4000_0000);
      check("cmd_op", {20'd0, fpu_op_o}, 32'h0000_0001);
      fpu_ready_i = 1'b1;
      tick();
      fpu_ready_i = 1'b0;
      check("cmd_issued_once", issue_count, 32'd1);
      check("cmd_valid_after", {31'd0, fpu_valid_o}, 32'd0);
      wb_access(1'b1, OFF_A, 32'h1234_ABCD, 4'b0011, d);
      rd(OFF_A, d);
      check("sel_merge_a", d, 32'h3F80_ABCD);
      rd(OFF_OP, d);
      check("op_no_valid", d, 32'h0000_0001);
      core_return();
      rd(OFF_FLAGS, d);
      rd(OFF_FLAGS, d2);
      check("flags_val", d, {27'd0, exp_q[0][36:32]});
      check("flags_repeat", d2, d);
      rd(OFF_STATUS, d);
      check("flags_no_pop", {24'd0, d[15:8]}, 32'd1);
      read_res("res_basic");

      // underflow
      rd(OFF_RES, d);
      check("unf_dat", d, 32'd0);
      rd(OFF_STATUS, d);
      check("unf_bit", {31'd0, d[25]}, 32'd1);
      wb_access(1'b1, OFF_STATUS, 32'h0200_0000, 4'b1000, d);
      rd(OFF_STATUS, d);
      check("unf_clr", d, 32'h0002_0000);

      // overflow with core stalled
      stage(32'h1111_0000, 32'h0000_2222, 32'h0F0F_0F0F, 3'd3);
      for (int i = 0; i < 5; i++) commit(12'h100 + 12'(i), (i < 4));
      rd(OFF_STATUS, d);
      check("ovf_status", d, 32'h0103_0004);
      wr(OFF_STATUS, 32'h0100_0000);
      rd(OFF_STATUS, d);
      check("ovf_clr", d, 32'h0003_0004);

      // result-space backpressure
      base_issue = issue_count;
      fpu_ready_i = 1'b1;
      stage(32'hC000_0000, 32'h4049_0FDB, 32'd0, 3'd1);
      commit(12'h0A5, 1'b1);
      commit(12'h05A, 1'b1);
      repeat (5) tick();
      check("bp_issued4", issue_count - base_issue, 32'd4);
      rd(OFF_STATUS, d);
      check("bp_status", d, 32'h0002_0002);
      for (int i = 0; i < 4; i++) core_return();
      rd(OFF_STATUS, d);
      check("bp_res_full", d, 32'h0000_0402);
      check("bp_no_issue", issue_count - base_issue, 32'd4);
      check("bp_valid_low", {31'd0, fpu_valid_o}, 32'd0);
      read_res("bp_res0");
      check("bp_valid_after_pop", {31'd0, fpu_valid_o}, 32'd1);
      tick();
      check("bp_fifth_issued", issue_count - base_issue, 32'd5);
      for (int i = 0; i < 3; i++) read_res("bp_res_drain");
      core_return();
      core_return();
      read_res("bp_res5");
      read_res("bp_res6");

      // interrupt
      wr(OFF_CTRL, 32'h0000_0001);
      commit(12'h777, 1'b1);
      core_return();
      check("irq_lag", {31'd0, irq_o}, 32'd0);
      tick();
      check("irq_rise", {31'd0, irq_o}, 32'd1);
      read_res("irq_res");
      tick();
      check("irq_fall", {31'd0, irq_o}, 32'd0);

      // flush with two in flight
      commit(12'h011, 1'b1);
      commit(12'h022, 1'b1);
      for (int i = 0; i < 20 && inflight.size() < 2; i++) tick();
      fpu_ready_i = 1'b0;
      check("flush_inflight", inflight.size(), 32'd2);
      wr(OFF_CTRL, 32'h0000_0003);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      core_return();
      core_return();
      rd(OFF_STATUS, d);
      check("flush_status", d, 32'h0402_0000);
      rd(OFF_CTRL, d);
      check("flush_selfclr", d, 32'h0000_0001);

      // reset in the middle of a bus read
      commit(12'h0EE, 1'b1);
      void'(exp_q.pop_back());
      check("pre_rst_valid", {31'd0, fpu_valid_o}, 32'd1);
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
      wbs_adr_i = BASE | 32'h14; wbs_sel_i = 4'hF;
      rst = 1'b1;
      tick();
      check("mid_rst_ack", {31'd0, wbs_ack_o}, 32'd0);
      check("mid_rst_dat", wbs_dat_o, 32'd0);
      check("mid_rst_valid", {31'd0, fpu_valid_o}, 32'd0);
      check("mid_rst_a", fpu_a_o, 32'd0);
      check("mid_rst_irq", {31'd0, irq_o}, 32'd0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      rst = 1'b0;
      tick();
      rd(OFF_STATUS, d);
      check("post_rst_status", d, 32'h0002_0000);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
